multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the execute stage, alongside the combinational ALU. It takes the same two register operands the ALU does, runs a fixed-latency shift-add multiply or shift-subtract divide, and returns a 32-bit result with an exception flag. The execute-stage result mux selects it instead of the ALU result when `data_resultRDY` fires. The pipeline stalls on `busy`.

---
 rtl/multdiv.sv | 170 +++++++++++++++++
 tb/tb_multdiv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// multdiv -- iterative signed 32-bit multiply / divide unit for the execute stage.
//
// Radix-2 Booth multiply or restoring divide on magnitudes. Each op takes
// 32 iterations plus one finishing cycle. Latency is fixed: the accept edge
// is E0, and data_resultRDY is high for the one cycle after E33.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-low; clears all state
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse (wins if ctrl_DIV is also high)
//   ctrl_DIV        start-divide pulse
//   data_result     product low word or quotient (registered, held)
//   data_exception  overflow / divide-by-zero of the completed op (registered)
//   data_resultRDY  one-cycle pulse: result and exception valid
//   busy            high from the cycle after accept through the resultRDY cycle
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  count;

  // Booth register {hi, lo, q-1}. hi carries one guard bit so that adding or
  // subtracting a multiplicand of -2^31 can never overflow the accumulator.
  logic [65:0] booth;
  logic [32:0] mcand;

  // Divider: partial remainder, dividend/quotient shift register, divisor magnitude.
  logic [32:0] rem;
  logic [31:0] quo;
  logic [32:0] dmag;
  logic        neg;
  logic        div_zero;
  logic        div_ovf;

  logic [32:0] booth_hi;
  logic [32:0] hi_sum;
  logic [65:0] booth_step;
  logic [63:0] product;
  logic        mul_ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic        div_fits;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_signed;

  always_comb begin
    // Booth step: examine {lo[0], q-1}, add/subtract multiplicand into hi,
    // then arithmetic shift the whole register right by one.
    booth_hi = booth[65:33];
    case (booth[1:0])
      2'b01:   hi_sum = booth_hi + mcand;
      2'b10:   hi_sum = booth_hi - mcand;
      default: hi_sum = booth_hi;
    endcase
    booth_step = {hi_sum[32], hi_sum, booth[32:1]};
    product    = booth[64:1];
    // Signed overflow: the upper 33 product bits must all equal the sign bit.
    mul_ovf    = !((&product[63:31]) || !(|product[63:31]));

    // Magnitudes read as unsigned; 0x80000000 maps to 2^31 exactly, and the
    // divisor is zero-extended to 33 bits for the trial subtraction.
    a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if the divisor fits.
    rem_shift  = {rem[31:0], quo[31]};
    div_fits   = (rem_shift >= dmag);
    rem_step   = div_fits ? (rem_shift - dmag) : rem_shift;
    quo_step   = {quo[30:0], div_fits};
    quo_signed = neg ? (32'd0 - quo) : quo;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= 6'd0;
      booth          <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dmag           <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          count <= 6'd0;
          if (ctrl_MULT) begin
            state <= MUL;
            busy  <= 1'b1;
            mcand <= {data_operandA[31], data_operandA};
            booth <= {33'd0, data_operandB, 1'b0};
          end else if (ctrl_DIV) begin
            state    <= DIV;
            busy     <= 1'b1;
            rem      <= 33'd0;
            quo      <= a_mag;
            dmag     <= {1'b0, b_mag};
            neg      <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
          end
        end
        MUL: begin
          // count==32 is the finishing cycle after the 32 Booth iterations.
          if (count == 6'd32) begin
            data_result    <= product[31:0];
            data_exception <= mul_ovf;
            data_resultRDY <= 1'b1;
            state          <= DONE;
          end else begin
            booth <= booth_step;
            count <= count + 6'd1;
          end
        end
        DIV: begin
          // Special cases run the full iteration count and are overridden here.
          if (count == 6'd32) begin
            if (div_zero) begin
              data_result    <= 32'd0;
              data_exception <= 1'b1;
            end else if (div_ovf) begin
              data_result    <= 32'h8000_0000;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quo_signed;
              data_exception <= 1'b0;
            end
            data_resultRDY <= 1'b1;
            state          <= DONE;
          end else begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 6'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= 6'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv -- self-checking bench for multdiv.
//
// A behavioural model (plain integer multiply/divide plus a cycle-phase
// counter since the accept edge) predicts resultRDY, busy, result and
// exception; a compare process checks all four every falling edge. Directed
// operations with hand-computed results pin the model, followed by a long
// randomized run with frequent, overlapping start pulses.
module tb_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the operation's definition.
  function automatic void model_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic exc);
    longint pa, pb, p;
    int     qa, qb;
    if (is_mul) begin
      pa  = $signed(a);
      pb  = $signed(b);
      p   = pa * pb;
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      qa  = $signed(a);
      qb  = $signed(b);
      res = qa / qb;
      exc = 1'b0;
    end
  endfunction

  // phase = number of the cycle since the accept edge (1 = cycle after E0);
  // 0 means idle. resultRDY is expected in phase 34 (cycle after E33).
  int          phase;
  logic [31:0] m_res, pend_res;
  logic        m_exc, pend_exc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase = 0;
      m_res = 32'd0;
      m_exc = 1'b0;
    end else if (phase == 0) begin
      if (ctrl_MULT || ctrl_DIV) begin
        model_op(ctrl_MULT, data_operandA, data_operandB, pend_res, pend_exc);
        phase = 1;
      end
    end else if (phase == 34) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 34) begin
        m_res = pend_res;
        m_exc = pend_exc;
      end
    end
  end

  always @(negedge clock) begin
    chk("resultRDY", {31'd0, data_resultRDY}, {31'd0, phase == 34});
    chk("busy", {31'd0, busy}, {31'd0, phase != 0});
    chk("result", data_result, m_res);
    chk("exception", {31'd0, data_exception}, {31'd0, m_exc});
    if (data_resultRDY)
      $display("op complete: result=%h exception=%b (t=%0t)", data_result, data_exception, $time);
  end

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  // One operation with a hand-computed expectation; operands are scrambled
  // right after the accept edge to prove the unit works from its own copies.
  task automatic do_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_e, input string name);
    int lat;
    bit got;
    @(posedge clock); #1;
    ctrl_MULT = mul; ctrl_DIV = div; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (data_resultRDY) got = 1'b1;
    end
    chk({name, " rdy seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({name, " latency"}, lat, 34);
      chk({name, " result"}, data_result, exp_r);
      chk({name, " exception"}, {31'd0, data_exception}, {31'd0, exp_e});
    end
  endtask

  task automatic count_rdy(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int lat;
    bit got;
    reset = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset result", data_result, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b1;

    do_op(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul 7*-3");
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul 2^16*2^16");
    do_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0, "mul max*1");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div -7/2");
    do_op(1'b0, 1'b1, 32'd100,       32'd7,         32'h0000_000E, 1'b0, "div 100/7");
    do_op(1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1, "div 5/0");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div min/-1");
    do_op(1'b1, 1'b1, 32'd6,         32'd3,         32'd18,        1'b0, "mul+div 6,3");

    // DIV pulse during a MULT (at E10) must be ignored.
    @(posedge clock); #1;
    ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd9;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd3;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (data_resultRDY) got = 1'b1;
    end
    chk("ignored div rdy seen", {31'd0, got}, 32'd1);
    chk("ignored div result", data_result, 32'd45);
    count_rdy(40, pulses);
    chk("ignored div extra rdy", pulses, 0);

    // Reset at E15 of a MULT aborts it with no resultRDY.
    @(posedge clock); #1;
    ctrl_MULT = 1'b1; data_operandA = 32'd11; data_operandB = 32'd13;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort result", data_result, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort exception", {31'd0, data_exception}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    count_rdy(40, pulses);
    chk("abort no rdy", pulses, 0);
    do_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, "mul 3*4 after reset");

    // Randomized run: frequent and overlapping starts, special operands.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      ctrl_MULT     = ($urandom % 6 == 0);
      ctrl_DIV      = ($urandom % 6 == 0);
      data_operandA = pick();
      data_operandB = pick();
    end
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
